// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the RV32I single-cycle datapath.
// One fetch is in flight at a time; the fetched word is held until it retires.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request valid, address held until memory accepts
// WAIT  | request accepted, waiting for the response word
// HOLD  | instruction presented to decode/execute until retire
// FAULT | misaligned next PC, fetch halted until reset
module pc_fetch_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            pc_src_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            misalign_fault_o
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fault_q, fault_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    next_pc    = pc_src_i ? branch_target_i : pc_plus4_i;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          instr_d    = imem_rsp_data_i;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          // A misaligned target halts fetch and leaves the PC at the offending instruction.
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    req_valid_d   = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_VECTOR;
      fault_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign pc_o             = pc_q;
  assign imem_req_addr_o  = pc_q;
  assign imem_req_valid_o = req_valid_q;
  assign instr_valid_o    = instr_valid_q;
  assign instr_o          = instr_q;
  assign instr_pc_o       = instr_pc_q;
  assign misalign_fault_o = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a small memory driver plus a
// scoreboard of expected fetch addresses and delivered instructions.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_i;
  logic [31:0] branch_target_i;
  logic        pc_src_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        misalign_fault_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int hs_cnt;

  logic [31:0] addr_q[$];
  sb_t         sb_q[$];

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_o             (pc_o),
    .pc_plus4_i       (pc_plus4_i),
    .branch_target_i  (branch_target_i),
    .pc_src_i         (pc_src_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i),
    .misalign_fault_o (misalign_fault_o)
  );

  // external PC+4 adder, wraps modulo 2^32
  assign pc_plus4_i = pc_o + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_cnt <= 0;
    else if (imem_req_valid_o && imem_req_ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_wait", {31'd0, ok}, 32'd1);
  endtask

  // One full fetch: request (with stall), response (with latency), retire.
  task automatic fetch(input logic [31:0] data, input int stall, input int lat,
                       input bit spur, input bit src, input logic [31:0] tgt,
                       output int t_req, output int t_vld, output int t_next);
    logic [31:0] ea, nxt;
    int h0;
    bit ok;
    sb_t e;
    t_req = -1; t_vld = -1; t_next = -1;
    wait_req(ok);
    if (!ok) return;
    t_req = cyc;
    ea = (addr_q.size() != 0) ? addr_q.pop_front() : JUNK;
    chk("req_addr", imem_req_addr_o, ea);
    h0 = hs_cnt;
    for (int i = 0; i < stall; i++) begin
      imem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("bp_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("bp_addr", imem_req_addr_o, ea);
    end
    imem_req_ready_i = 1'b1;
    if (spur) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = JUNK;
    end
    sb_q.push_back('{instr: data, pc: ea});
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    chk("hs_count", hs_cnt - h0, 32'd1);
    chk("wait_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    chk("wait_ivalid", {31'd0, instr_valid_o}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("lat_ivalid", {31'd0, instr_valid_o}, 32'd0);
      chk("lat_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = JUNK;
    t_vld = cyc;
    chk("hold_ivalid", {31'd0, instr_valid_o}, 32'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '{instr: JUNK, pc: JUNK};
    chk("instr", instr_o, e.instr);
    chk("instr_pc", instr_pc_o, e.pc);
    if (spur) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~data;
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = JUNK;
      chk("spur_instr", instr_o, e.instr);
      chk("spur_ivalid", {31'd0, instr_valid_o}, 32'd1);
    end
    nxt = src ? tgt : ea + 32'd4;
    pc_src_i        = src;
    branch_target_i = tgt;
    instr_ready_i   = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    pc_src_i      = 1'b0;
    t_next = cyc;
    chk("retire_ivalid", {31'd0, instr_valid_o}, 32'd0);
    if (nxt[1:0] != 2'b00) begin
      chk("fault", {31'd0, misalign_fault_o}, 32'd1);
      chk("fault_pc", pc_o, ea);
      chk("fault_req", {31'd0, imem_req_valid_o}, 32'd0);
    end else begin
      chk("no_fault", {31'd0, misalign_fault_o}, 32'd0);
      chk("next_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("next_pc", pc_o, nxt);
      addr_q.push_back(nxt);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid_o}, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, NOP);
    chk({tag, "_instr_pc"}, instr_pc_o, 32'h0);
    chk({tag, "_fault"}, {31'd0, misalign_fault_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tr, tv, tn, h0;
    bit ok;
    logic [31:0] ea;
    rst_n = 1'b0;
    branch_target_i  = '0;
    pc_src_i         = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = JUNK;
    instr_ready_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    #1;
    chk("idle_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    @(negedge clk);
    addr_q.push_back(32'h0);

    // first fetch, zero-wait memory: req in 1, valid in 3, next req in 4
    fetch(32'h0040_0093, 0, 0, 0, 1'b0, 32'h0, tr, tv, tn);
    chk("t_req", tr, 32'd1);
    chk("t_vld", tv, 32'd3);
    chk("t_next", tn, 32'd4);

    // sequential 0x4..0xC, then branch from 0x10 to 0x100
    for (int k = 1; k <= 3; k++)
      fetch(32'h0000_0093 + 32'(k << 20), 0, 0, 0, 1'b0, 32'h0, tr, tv, tn);
    fetch(32'h0000_0463, 0, 0, 0, 1'b1, 32'h100, tr, tv, tn);

    // back-pressure 3 cycles, response latency 4, spurious responses
    fetch(32'h00A0_0113, 3, 4, 1, 1'b0, 32'h0, tr, tv, tn);
    chk("lat_t_vld", tv - tr, 32'd9);

    // reset while WAIT, then the stale response arrives
    wait_req(ok);
    ea = (addr_q.size() != 0) ? addr_q.pop_front() : JUNK;
    chk("pre_rst_addr", imem_req_addr_o, ea);
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h1234_5678;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = JUNK;
    chk("stale_ivalid", {31'd0, instr_valid_o}, 32'd0);
    chk("stale_instr", instr_o, NOP);
    chk("restart_addr", imem_req_addr_o, 32'h0);
    addr_q.delete();
    sb_q.delete();
    addr_q.push_back(32'h0);

    // wrap-around via 0xFFFF_FFFC, then misaligned branch from 0x4
    fetch(32'h0000_006F, 0, 1, 0, 1'b1, 32'hFFFF_FFFC, tr, tv, tn);
    fetch(32'h0010_0093, 0, 0, 0, 1'b0, 32'h0, tr, tv, tn);
    fetch(32'h0020_0093, 0, 0, 0, 1'b0, 32'h0, tr, tv, tn);
    fetch(32'h0020_0063, 0, 0, 0, 1'b1, 32'h102, tr, tv, tn);
    h0 = hs_cnt;
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fault_hold_req", {31'd0, imem_req_valid_o}, 32'd0);
      chk("fault_sticky", {31'd0, misalign_fault_o}, 32'd1);
      chk("fault_hold_pc", pc_o, 32'h4);
    end
    imem_req_ready_i = 1'b0;
    chk("fault_no_hs", hs_cnt - h0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
